// File: rtl/ben_clock_gen_pkg.sv
// ben_clock_pkg: shared types and defaults for the CPU clock generator.
//   state_e      : FSM states of ben_clock_gen
//   DEF_DIVIDER  : default phase length in board-clock cycles
//   DEF_DEBOUNCE : default number of stable cycles to accept a Step change
package ben_clock_pkg;

   typedef enum logic [2:0] {
      RUN_LOW,
      RUN_HIGH,
      IDLE,
      STEP_HIGH,
      STEP_LOW
   } state_e;

   localparam int DEF_DIVIDER  = 4;
   localparam int DEF_DEBOUNCE = 8;

endpackage

// File: rtl/ben_clock_gen_if.sv
// ben_clock_gen_if: control inputs and clock outputs of the clock generator.
//   Manual    : mode select (1 = single-step), asynchronous
//   Step      : raw push-button, asynchronous and bouncy
//   Halt      : CPU HLT, synchronous to the board clock
//   ClkOut    : CPU clock
//   notClkOut : inverse CPU clock
//   Tick      : one-cycle pulse in the first cycle ClkOut is high
// master drives the controls (bench / CPU side); slave is the generator.
interface ben_clock_gen_if;

   logic Manual;
   logic Step;
   logic Halt;
   logic ClkOut;
   logic notClkOut;
   logic Tick;

   modport master (output Manual, Step, Halt,
                   input  ClkOut, notClkOut, Tick);

   modport slave  (input  Manual, Step, Halt,
                   output ClkOut, notClkOut, Tick);

endinterface

// File: rtl/ben_clock_gen_step_debouncer.sv
// step_debouncer: turns the raw Step button into a clean one-cycle pulse.
//   C            : board clock
//   Reset        : asynchronous active-high reset
//   step_i       : raw, asynchronous, bouncy button level
//   step_pulse_o : one-cycle pulse on each accepted 0->1 change
// A 2-flop synchronizer feeds a stable-count filter: the accepted level only
// follows the synced level after DEBOUNCE consecutive disagreeing cycles.
module step_debouncer #(
   parameter int DEBOUNCE = 8
) (
   input  logic C,
   input  logic Reset,
   input  logic step_i,
   output logic step_pulse_o
);

   localparam int             DW    = $clog2(DEBOUNCE) + 1;
   localparam logic [DW-1:0]  DLAST = DW'(DEBOUNCE - 1);

   logic [1:0]    sync_q;
   logic          level_q;
   logic          level_prev_q;
   logic [DW-1:0] cnt_q;

   always_ff @(posedge C or posedge Reset) begin
      if (Reset) begin
         sync_q       <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync_q       <= {sync_q[0], step_i};
         level_prev_q <= level_q;
         // Any agreeing cycle restarts the count; the level flips on the
         // DEBOUNCE-th disagreeing cycle and the count clears, so it never wraps.
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DLAST) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + DW'(1);
         end
      end
   end

   assign step_pulse_o = level_q & ~level_prev_q;

endmodule

// File: rtl/ben_clock_gen.sv
// ben_clock_gen: CPU clock source derived from the board clock C.
//   C     : board clock, the only clock
//   Reset : asynchronous active-high reset
//   bus   : slave side of ben_clock_gen_if (Manual/Step/Halt in,
//           ClkOut/notClkOut/Tick out, all outputs registered)
// Astable mode gives DIVIDER cycles high / DIVIDER low. Mode and Halt are only
// acted on at the end of a low phase, so high and low phases are never shorter
// than DIVIDER cycles. Manual mode emits one high+low cycle per debounced press.
module ben_clock_gen
   import ben_clock_pkg::*;
#(
   parameter int DIVIDER  = DEF_DIVIDER,
   parameter int DEBOUNCE = DEF_DEBOUNCE
) (
   input  logic          C,
   input  logic          Reset,
   ben_clock_gen_if.slave bus
);

   localparam int            CW   = $clog2(DIVIDER) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    man_q;
   logic          man_sync;
   logic          clk_q, nclk_q, tick_q;
   logic          clk_d, tick_d;
   logic          step_pulse;

   step_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step (
      .C            (C),
      .Reset        (Reset),
      .step_i       (bus.Step),
      .step_pulse_o (step_pulse)
   );

   assign man_sync = man_q[1];

   always_ff @(posedge C or posedge Reset) begin
      if (Reset) begin
         state_q <= RUN_LOW;
         cnt_q   <= '0;
         man_q   <= '0;
         clk_q   <= 1'b0;
         nclk_q  <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         man_q   <= {man_q[0], bus.Manual};
         clk_q   <= clk_d;
         nclk_q  <= ~clk_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      tick_d  = 1'b0;
      unique case (state_q)
         RUN_LOW: begin
            if (cnt_q == LAST) begin
               if (man_sync) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (bus.Halt) begin
                  // Park at the end of the low phase so release rises at once.
                  cnt_d = cnt_q;
               end else begin
                  state_d = RUN_HIGH;
                  cnt_d   = '0;
                  tick_d  = 1'b1;
               end
            end
         end
         RUN_HIGH: begin
            if (cnt_q == LAST) begin
               state_d = RUN_LOW;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            cnt_d = '0;
            // Pulses seen here with Halt set, or in any other state, are dropped.
            if (!man_sync) begin
               state_d = RUN_LOW;
            end else if (step_pulse && !bus.Halt) begin
               state_d = STEP_HIGH;
               tick_d  = 1'b1;
            end
         end
         STEP_HIGH: begin
            if (cnt_q == LAST) begin
               state_d = STEP_LOW;
               cnt_d   = '0;
            end
         end
         STEP_LOW: begin
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RUN_LOW;
            cnt_d   = '0;
         end
      endcase
      clk_d = (state_d == RUN_HIGH) || (state_d == STEP_HIGH);
   end

   assign bus.ClkOut    = clk_q;
   assign bus.notClkOut = nclk_q;
   assign bus.Tick      = tick_q;

endmodule

// File: doc/ben_clock_gen.md
# ben_clock_gen

Clock-source block for the 8-bit CPU: from the board clock it produces the CPU clock consumed by every register and flip-flop in the datapath. It supports free-running (astable) mode, debounced single-step (manual) mode, and the CPU HLT input, with glitch-free switching between modes. Its output drives the clock input of the datapath flip-flops; `Tick` gives the same rising-edge instants as a single-cycle enable.

## Interface
- `DIVIDER`, default 4: length of each clock phase, in `C` cycles (high = low = DIVIDER). Must be ≥ 1.
- `DEBOUNCE`, default 8: number of consecutive stable `C` cycles before a `Step` level change is accepted. Must be ≥ 1.

Ports:
- `C`  in  1  board clock. This is the only clock; all state is clocked on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Manual`  in  1  mode select, 1 = single-step, 0 = astable. Asynchronous input; synchronized internally with 2 flops.
- `Step`  in  1  raw push-button. Asynchronous and bouncy.
- `Halt`  in  1  CPU HLT. Synchronous to `C`.
- `ClkOut`  out  1  CPU clock. Registered.
- `notClkOut`  out  1  inverse of `ClkOut`. Registered.
- `Tick`  out  1  one-`C`-cycle pulse, high in the first cycle that `ClkOut` is high.

## Operation
- **Reset values** (held while `Reset`=1):
  - `ClkOut`=0, `notClkOut`=1, `Tick`=0.
  - State RUN_LOW, phase counter 0.
  - Manual synchronizer = 0; debounced Step = 0.
- **Reset mid-operation:** `ClkOut` drops immediately. A truncated high phase is accepted.
- **States:**
  - RUN_LOW: counter increments each cycle. At counter == DIVIDER-1, the transition is chosen in this priority order:
    - synced Manual = 1 → IDLE.
    - else `Halt` = 1 → stay in RUN_LOW with the counter held.
    - else → RUN_HIGH with counter 0, `ClkOut`←1, `Tick`←1.
  - RUN_HIGH: counter increments. At counter == DIVIDER-1 → RUN_LOW with counter 0, `ClkOut`←0. The high phase is never cut short by `Halt` or `Manual`.
  - IDLE: `ClkOut` = 0.
    - If synced Manual = 0 → RUN_LOW with counter 0.
    - Else, on a step pulse with `Halt` = 0 → STEP_HIGH with counter 0, `ClkOut`←1, `Tick`←1.
  - STEP_HIGH: lasts DIVIDER cycles → STEP_LOW.
  - STEP_LOW: lasts DIVIDER cycles with `ClkOut` = 0 → IDLE.
- **Step handling:**
  - 2-flop synchronizer, then the debouncer. The debounced level follows the synced level only after DEBOUNCE consecutive cycles of disagreement; any agreeing cycle restarts the count.
  - A step pulse is the debounced 0→1 edge, one cycle wide.
  - Step pulses arriving outside IDLE, or while `Halt` = 1, are discarded, never queued. Holding the button yields exactly one step.
- **Widths:**
  - Phase counter is $clog2(DIVIDER)+1 bits.
  - Debounce counter is $clog2(DEBOUNCE)+1 bits.
  - Neither counter wraps: each is cleared on every state change.
- **Guaranteed widths:** every `ClkOut` high and low phase is ≥ DIVIDER `C` cycles, except a truncated high phase on `Reset`.

## Timing
- **Astable period:** 2·DIVIDER `C` cycles. First rise is on the DIVIDER-th `C` edge after `Reset` deasserts.
- **Halt:**
  - Sampled only at the end of a low phase.
  - If `Halt` rises during a high phase, that phase completes and `ClkOut` then stays low.
  - `ClkOut` rises on the first edge at which `Halt` = 0 again.
- **Step latency:** `Step` stable high → `ClkOut` rise after 2 (sync) + DEBOUNCE + 1 cycles.
- **Manual change latency:**
  - 2 sync cycles.
  - Then takes effect only at the end of a RUN_LOW phase or in IDLE.
- **`Tick` and `notClkOut`:** change on the same `C` edge as `ClkOut`. `notClkOut` is always equal to ~`ClkOut`.

## Structure
- Package `ben_clock_pkg`:
  - state enum typedef: RUN_LOW, RUN_HIGH, IDLE, STEP_HIGH, STEP_LOW.
  - default DIVIDER and DEBOUNCE constants.
- Sub-module `step_debouncer`:
  - 2-flop synchronizer, stable-count debouncer, and rising-edge pulse.
  - Ports: `C`, `Reset`, raw input, one-cycle pulse output.
  - Parameter: DEBOUNCE.
- The Manual synchronizer and the FSM live in the top module.

## Test plan
All scenarios use DIVIDER=4 and DEBOUNCE=8.
- **Free run:** `Reset` pulse, `Manual`=0, `Halt`=0 → `ClkOut` rises at edge 4 and falls at edge 8, period 8. `Tick` is high exactly one cycle per rise. `notClkOut` = ~`ClkOut` throughout.
- **Halt:** `Halt`=1 asserted in cycle 2 of a high phase → high lasts 4 cycles in total, then `ClkOut` stays low for 20+ cycles. Releasing `Halt` → `ClkOut` rises on the next edge.
- **Bounce rejection:** `Manual`=1, `Step` toggled every 3 cycles for 30 cycles → no `ClkOut` pulse. `Step` then held high → exactly one 4-cycle high pulse, rising 11 cycles after the hold begins, followed by ≥4 low cycles.
- **No re-trigger:** `Step` held high for 100 cycles → one pulse only. A second clean press landing in STEP_LOW → ignored. A third press after IDLE → one pulse.
- **Mode switch:** `Manual` 0→1 mid high phase → high completes (4 cycles), then low completes (4 cycles), then `ClkOut` stays 0. `Manual` 1→0 → first rise 4 cycles after the synced change.
- **Async reset:** `Reset` asserted mid high phase, between `C` edges → `ClkOut`=0 and `notClkOut`=1 before the next `C` edge. After release, the free-run timing above repeats.
